// File: rtl/hdmi_period_scheduler.sv
// hdmi_period_scheduler: raster timing and TMDS period sequencer for an HDMI transmitter.
// Ports:
//   clk_pixel_i        pixel clock, the only clock
//   reset_i            synchronous active-high reset
//   packet_pending_i   packet assembler has a packet ready
//   cx_o / cy_o        current column / line
//   video_active_o     current pixel is active video
//   mode_o             0 control, 1 video, 2 video guard, 3 island, 4 island guard
//   ctl_o              {CTL3,CTL2,CTL1,CTL0} preamble bits
//   hsync_o / vsync_o  sync levels
//   packet_start_o     pulse on first cycle of each packet body
//   packet_pos_o       cycle index within packet body, 0 outside island data
module hdmi_period_scheduler #(
    parameter int FRAME_WIDTH   = 800,
    parameter int FRAME_HEIGHT  = 525,
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480,
    parameter int HSYNC_START   = 656,
    parameter int HSYNC_LEN     = 96,
    parameter int VSYNC_START   = 490,
    parameter int VSYNC_LEN     = 2,
    parameter bit SYNC_POL      = 1'b0,
    parameter int ISLAND_START  = 644,
    parameter int MAX_PACKETS   = 2
) (
    input  logic                            clk_pixel_i,
    input  logic                            reset_i,
    input  logic                            packet_pending_i,
    output logic [$clog2(FRAME_WIDTH)-1:0]  cx_o,
    output logic [$clog2(FRAME_HEIGHT)-1:0] cy_o,
    output logic                            video_active_o,
    output logic [2:0]                      mode_o,
    output logic [3:0]                      ctl_o,
    output logic                            hsync_o,
    output logic                            vsync_o,
    output logic                            packet_start_o,
    output logic [4:0]                      packet_pos_o
);
    localparam int CW = $clog2(FRAME_WIDTH);
    localparam int RW = $clog2(FRAME_HEIGHT);

    if (ISLAND_START < SCREEN_WIDTH + 4 ||
        ISLAND_START + 24 + 32 * MAX_PACKETS > FRAME_WIDTH - 10 ||
        MAX_PACKETS < 1 || MAX_PACKETS > 18) begin : g_illegal
        $error("hdmi_period_scheduler: illegal island/frame parameters");
    end

    localparam logic [CW-1:0] FW_M1  = CW'(FRAME_WIDTH - 1);
    localparam logic [CW-1:0] FW_M2  = CW'(FRAME_WIDTH - 2);
    localparam logic [CW-1:0] FW_M3  = CW'(FRAME_WIDTH - 3);
    localparam logic [CW-1:0] FW_M10 = CW'(FRAME_WIDTH - 10);
    localparam logic [CW-1:0] SW_C   = CW'(SCREEN_WIDTH);
    localparam logic [CW-1:0] HS_B   = CW'(HSYNC_START);
    localparam logic [CW-1:0] HS_E   = CW'(HSYNC_START + HSYNC_LEN);
    localparam logic [CW-1:0] IS_M1  = CW'(ISLAND_START - 1);
    localparam logic [RW-1:0] FH_M1  = RW'(FRAME_HEIGHT - 1);
    localparam logic [RW-1:0] SH_C   = RW'(SCREEN_HEIGHT);
    localparam logic [RW-1:0] SH_M1  = RW'(SCREEN_HEIGHT - 1);
    localparam logic [RW-1:0] VS_B   = RW'(VSYNC_START);
    localparam logic [RW-1:0] VS_E   = RW'(VSYNC_START + VSYNC_LEN);
    localparam logic [4:0]    MAXP_C = 5'(MAX_PACKETS);

    typedef enum logic [2:0] {S_IDLE, S_PRE, S_LGUARD, S_PACKET, S_TGUARD} state_t;

    state_t        state_q, state_d;
    logic [4:0]    pos_q, pos_d;
    logic [4:0]    npk_q, npk_d;
    logic [CW-1:0] cx_q, cx_d;
    logic [RW-1:0] cy_q, cy_d;
    logic          va_q, va_d;
    logic [2:0]    mode_q, mode_d;
    logic [3:0]    ctl_q, ctl_d;
    logic          hs_q, hs_d;
    logic          vs_q, vs_d;
    logic          ps_q, ps_d;
    logic [4:0]    pp_q, pp_d;
    logic          next_act, vid_pre, vid_grd;

    // Island sequencer runs on the current pixel; its next state describes the next pixel.
    always_comb begin
        state_d = state_q;
        pos_d   = pos_q + 5'd1;
        npk_d   = npk_q;
        case (state_q)
            S_IDLE: begin
                pos_d = '0;
                npk_d = '0;
                if (cx_q == IS_M1 && packet_pending_i) state_d = S_PRE;
            end
            S_PRE: begin
                if (pos_q == 5'd7) begin
                    state_d = S_LGUARD;
                    pos_d   = '0;
                end
            end
            S_LGUARD: begin
                if (pos_q == 5'd1) begin
                    state_d = S_PACKET;
                    pos_d   = '0;
                    npk_d   = npk_q + 5'd1;
                end
            end
            S_PACKET: begin
                if (pos_q == 5'd31) begin
                    pos_d = '0;
                    if (packet_pending_i && npk_q < MAXP_C) npk_d = npk_q + 5'd1;
                    else state_d = S_TGUARD;
                end
            end
            S_TGUARD: begin
                if (pos_q == 5'd1) begin
                    state_d = S_IDLE;
                    pos_d   = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are computed for the next pixel so every registered output lines up with cx/cy.
    always_comb begin
        cx_d     = (cx_q == FW_M1) ? '0 : cx_q + 1'b1;
        cy_d     = (cx_q != FW_M1) ? cy_q : (cy_q == FH_M1) ? '0 : cy_q + 1'b1;
        next_act = (cy_d < SH_M1) || (cy_d == FH_M1);
        vid_pre  = next_act && cx_d >= FW_M10 && cx_d <= FW_M3;
        vid_grd  = next_act && cx_d >= FW_M2;
        va_d     = (cx_d < SW_C) && (cy_d < SH_C);
        mode_d   = va_d ? 3'd1 :
                   vid_grd ? 3'd2 :
                   (state_d == S_PACKET) ? 3'd3 :
                   (state_d == S_LGUARD || state_d == S_TGUARD) ? 3'd4 : 3'd0;
        ctl_d    = vid_pre ? 4'b0001 : (state_d == S_PRE) ? 4'b0101 : 4'b0000;
        hs_d     = (cx_d >= HS_B && cx_d < HS_E) ? SYNC_POL : ~SYNC_POL;
        vs_d     = (cy_d >= VS_B && cy_d < VS_E) ? SYNC_POL : ~SYNC_POL;
        ps_d     = (state_d == S_PACKET) && (pos_d == 5'd0);
        pp_d     = (state_d == S_PACKET) ? pos_d : 5'd0;
    end

    always_ff @(posedge clk_pixel_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            pos_q   <= '0;
            npk_q   <= '0;
            cx_q    <= '0;
            cy_q    <= FH_M1;
            va_q    <= 1'b0;
            mode_q  <= 3'd0;
            ctl_q   <= 4'd0;
            hs_q    <= ~SYNC_POL;
            vs_q    <= ~SYNC_POL;
            ps_q    <= 1'b0;
            pp_q    <= '0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            npk_q   <= npk_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            va_q    <= va_d;
            mode_q  <= mode_d;
            ctl_q   <= ctl_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            ps_q    <= ps_d;
            pp_q    <= pp_d;
        end
    end

    assign cx_o           = cx_q;
    assign cy_o           = cy_q;
    assign video_active_o = va_q;
    assign mode_o         = mode_q;
    assign ctl_o          = ctl_q;
    assign hsync_o        = hs_q;
    assign vsync_o        = vs_q;
    assign packet_start_o = ps_q;
    assign packet_pos_o   = pp_q;
endmodule
